// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the RV32M divide unit.
package div_pkg;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_WAIT = 2'b01,
        S_DONE = 2'b10
    } div_state_e;

    localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] SIGNED_MIN    = 32'h8000_0000;

endpackage

// File: rtl/div_unit_divider.sv
// rtl/div_unit_divider.sv - 32-iteration restoring divider with stb/ack handshake.
module divider (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stb_i,
    input  logic        is_signed_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic        ack_o,
    output logic [31:0] quotient_o,
    output logic [31:0] remainder_o
);

    typedef enum logic [1:0] {D_IDLE, D_CALC, D_FIX} dstate_e;

    dstate_e     dstate;
    logic [31:0] quo_q;
    logic [31:0] rem_q;
    logic [31:0] den_q;
    logic [4:0]  cnt_q;
    logic        neg_quo_q;
    logic        neg_rem_q;
    logic        dividend_neg;
    logic        divisor_neg;
    logic [32:0] rem_sh;
    logic [32:0] diff;

    assign dividend_neg = is_signed_i & dividend_i[31];
    assign divisor_neg  = is_signed_i & divisor_i[31];
    assign rem_sh       = {rem_q, quo_q[31]};
    assign diff         = rem_sh - {1'b0, den_q};

    // Operands are divided as magnitudes; signs are restored in D_FIX.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dstate      <= D_IDLE;
            quo_q       <= '0;
            rem_q       <= '0;
            den_q       <= '0;
            cnt_q       <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            ack_o       <= 1'b0;
            quotient_o  <= '0;
            remainder_o <= '0;
        end else begin
            ack_o <= 1'b0;
            case (dstate)
                D_IDLE: begin
                    if (stb_i) begin
                        quo_q     <= dividend_neg ? -dividend_i : dividend_i;
                        den_q     <= divisor_neg ? -divisor_i : divisor_i;
                        rem_q     <= '0;
                        cnt_q     <= '0;
                        neg_quo_q <= dividend_neg ^ divisor_neg;
                        neg_rem_q <= dividend_neg;
                        dstate    <= D_CALC;
                    end
                end
                D_CALC: begin
                    if (!diff[32]) begin
                        rem_q <= diff[31:0];
                        quo_q <= {quo_q[30:0], 1'b1};
                    end else begin
                        rem_q <= rem_sh[31:0];
                        quo_q <= {quo_q[30:0], 1'b0};
                    end
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        dstate <= D_FIX;
                    end
                end
                D_FIX: begin
                    quotient_o  <= neg_quo_q ? -quo_q : quo_q;
                    remainder_o <= neg_rem_q ? -rem_q : rem_q;
                    ack_o       <= 1'b1;
                    dstate      <= D_IDLE;
                end
                default: dstate <= D_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - RV32M DIV/DIVU/REM/REMU unit with special-case bypass and one-entry result cache.
module div_unit
    import div_pkg::*;
#(
    parameter int ENABLE_CACHE = 1
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        stb_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    output logic [31:0] result_o,
    output logic        ack_o
);

    div_state_e  state;
    div_op_e     op_q;
    logic [31:0] rs1_q;
    logic [31:0] rs2_q;
    logic        div_stb;
    logic        div_ack;
    logic        div_rst;
    logic [31:0] div_quo;
    logic [31:0] div_rem;
    logic        is_special;
    logic [31:0] spec_quo;
    logic [31:0] spec_rem;
    logic        cache_hit;
    logic [31:0] hit_quo;
    logic [31:0] hit_rem;
    logic        cache_wr;

    assign div_rst  = ~rst_n_i;
    assign cache_wr = (state == S_WAIT) && div_ack;

    always_comb begin
        is_special = 1'b0;
        spec_quo   = '0;
        spec_rem   = '0;
        if (rs2_i == '0) begin
            is_special = 1'b1;
            spec_quo   = DIV_BY_ZERO_Q;
            spec_rem   = rs1_i;
        end else if (!op_i[0] && rs1_i == SIGNED_MIN && rs2_i == 32'hFFFF_FFFF) begin
            is_special = 1'b1;
            spec_quo   = SIGNED_MIN;
            spec_rem   = '0;
        end
    end

    // Cached entry keeps both quotient and remainder so DIV and REM of the same operands share one division.
    if (ENABLE_CACHE != 0) begin : g_cache
        logic        valid;
        logic        c_signed;
        logic [31:0] c_rs1;
        logic [31:0] c_rs2;
        logic [31:0] c_quo;
        logic [31:0] c_rem;

        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                valid    <= 1'b0;
                c_signed <= 1'b0;
                c_rs1    <= '0;
                c_rs2    <= '0;
                c_quo    <= '0;
                c_rem    <= '0;
            end else if (cache_wr) begin
                valid    <= 1'b1;
                c_signed <= ~op_q[0];
                c_rs1    <= rs1_q;
                c_rs2    <= rs2_q;
                c_quo    <= div_quo;
                c_rem    <= div_rem;
            end
        end

        assign cache_hit = valid && (c_rs1 == rs1_i) && (c_rs2 == rs2_i) && (c_signed == ~op_i[0]);
        assign hit_quo   = c_quo;
        assign hit_rem   = c_rem;
    end else begin : g_no_cache
        assign cache_hit = 1'b0;
        assign hit_quo   = '0;
        assign hit_rem   = '0;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state    <= S_IDLE;
            op_q     <= OP_DIV;
            rs1_q    <= '0;
            rs2_q    <= '0;
            div_stb  <= 1'b0;
            ack_o    <= 1'b0;
            result_o <= '0;
        end else begin
            div_stb <= 1'b0;
            ack_o   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (stb_i) begin
                        op_q  <= div_op_e'(op_i);
                        rs1_q <= rs1_i;
                        rs2_q <= rs2_i;
                        if (is_special) begin
                            result_o <= op_i[1] ? spec_rem : spec_quo;
                            ack_o    <= 1'b1;
                            state    <= S_DONE;
                        end else if (cache_hit) begin
                            result_o <= op_i[1] ? hit_rem : hit_quo;
                            ack_o    <= 1'b1;
                            state    <= S_DONE;
                        end else begin
                            div_stb <= 1'b1;
                            state   <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (div_ack) begin
                        result_o <= op_q[1] ? div_rem : div_quo;
                        ack_o    <= 1'b1;
                        state    <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    divider u_divider (
        .clk_i       (clk_i),
        .rst_i       (div_rst),
        .stb_i       (div_stb),
        .is_signed_i (~op_q[0]),
        .dividend_i  (rs1_q),
        .divisor_i   (rs2_q),
        .ack_o       (div_ack),
        .quotient_o  (div_quo),
        .remainder_o (div_rem)
    );

endmodule
